// File: rtl/data_port_arbiter.sv
// Two-master arbiter for the core's single data-memory port. Picks one requester,
// forwards its request fields, holds that choice until the memory grants it, and
// routes each in-order response back to the master that issued it.
module data_port_arbiter #(
  parameter int unsigned MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        data_req_o,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam int unsigned PtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUT + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUT - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUT);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} lock_e;

  lock_e           lock_q, lock_d;
  logic            rr_q;
  logic            fifo_q [MAX_OUT];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;

  logic sel_valid, sel_id;
  logic push, pop, blocked, head;

  // Response bookkeeping; a pop on an empty FIFO is a spurious rvalid and is dropped.
  always_comb begin
    head    = fifo_q[rptr_q];
    pop     = data_rvalid_i && (cnt_q != '0) && !rst;
    blocked = (cnt_q == CntFull) && !pop;
  end

  // Owner selection and lock next-state; a locked master keeps the port until granted.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = 1'b0;
    lock_d    = lock_q;
    if (!rst) begin
      unique case (lock_q)
        StIdle: begin
          if (!blocked) begin
            if (m0_req_i && m1_req_i) begin
              sel_valid = 1'b1;
              sel_id    = rr_q;
            end else if (m0_req_i) begin
              sel_valid = 1'b1;
              sel_id    = 1'b0;
            end else if (m1_req_i) begin
              sel_valid = 1'b1;
              sel_id    = 1'b1;
            end
          end
          if (sel_valid && !data_gnt_i) lock_d = sel_id ? StLock1 : StLock0;
        end
        StLock0: begin
          sel_valid = m0_req_i;
          sel_id    = 1'b0;
          // A dropped request abandons the lock without pushing an ID.
          if (!sel_valid || data_gnt_i) lock_d = StIdle;
        end
        StLock1: begin
          sel_valid = m1_req_i;
          sel_id    = 1'b1;
          if (!sel_valid || data_gnt_i) lock_d = StIdle;
        end
        default: lock_d = StIdle;
      endcase
    end
  end

  // Forward the selected master's fields; master 0 is the default mux leg.
  always_comb begin
    push         = sel_valid && data_gnt_i;
    data_req_o   = sel_valid;
    data_addr_o  = sel_id ? m1_addr_i  : m0_addr_i;
    data_we_o    = sel_id ? m1_we_i    : m0_we_i;
    data_be_o    = sel_id ? m1_be_i    : m0_be_i;
    data_wdata_o = sel_id ? m1_wdata_i : m0_wdata_i;
    m0_gnt_o     = push && !sel_id;
    m1_gnt_o     = push && sel_id;
    m0_rvalid_o  = pop && !head;
    m1_rvalid_o  = pop && head;
    m0_rdata_o   = data_rdata_i;
    m1_rdata_o   = data_rdata_i;
  end

  // Lock, round-robin pointer, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= StIdle;
      rr_q   <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      lock_q <= lock_d;
      if (push) begin
        rr_q   <= ~sel_id;
        wptr_q <= (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
      end
      if (pop) rptr_q <= (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!push && pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // ID storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= sel_id;
  end

endmodule

// File: tb/tb_data_port_arbiter.sv
// Self-checking bench for data_port_arbiter: a scoreboard queue holds the expected
// owner of each granted transaction and is popped as responses are driven.
module tb_data_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        data_req_o, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rdata_i;

  int total = 0;
  int bad   = 0;
  int sb_q[$];

  always #5 clk = ~clk;

  data_port_arbiter #(.MAX_OUT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_req_i     (m0_req_i),
    .m0_addr_i    (m0_addr_i),
    .m0_we_i      (m0_we_i),
    .m0_be_i      (m0_be_i),
    .m0_wdata_i   (m0_wdata_i),
    .m0_gnt_o     (m0_gnt_o),
    .m0_rvalid_o  (m0_rvalid_o),
    .m0_rdata_o   (m0_rdata_o),
    .m1_req_i     (m1_req_i),
    .m1_addr_i    (m1_addr_i),
    .m1_we_i      (m1_we_i),
    .m1_be_i      (m1_be_i),
    .m1_wdata_i   (m1_wdata_i),
    .m1_gnt_o     (m1_gnt_o),
    .m1_rvalid_o  (m1_rvalid_o),
    .m1_rdata_o   (m1_rdata_o),
    .data_req_o   (data_req_o),
    .data_addr_o  (data_addr_o),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .data_wdata_o (data_wdata_o),
    .data_gnt_i   (data_gnt_i),
    .data_rvalid_i(data_rvalid_i),
    .data_rdata_i (data_rdata_i)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, check the combinational outputs mid-cycle, then clock.
  // sel is the master expected on the port this cycle (-1 = none).
  task automatic cyc(input logic r0, input logic r1, input logic g, input logic rv,
                     input logic [31:0] rd, input int sel, input string tag);
    logic e_rv0, e_rv1;
    int   id;
    m0_req_i = r0; m1_req_i = r1; data_gnt_i = g; data_rvalid_i = rv; data_rdata_i = rd;
    #1;
    e_rv0 = 1'b0;
    e_rv1 = 1'b0;
    if (rv && sb_q.size() > 0) begin
      id = sb_q.pop_front();
      if (id == 0) e_rv0 = 1'b1;
      else         e_rv1 = 1'b1;
    end
    chk_val({tag, "_req"}, 32'(data_req_o), 32'(sel >= 0));
    if (sel == 0) begin
      chk_val({tag, "_addr"}, data_addr_o, 32'h0000_0100);
      chk_val({tag, "_we"}, 32'(data_we_o), 32'd0);
      chk_val({tag, "_be"}, 32'(data_be_o), 32'hF);
      chk_val({tag, "_wdata"}, data_wdata_o, 32'h1111_1111);
    end else if (sel == 1) begin
      chk_val({tag, "_addr"}, data_addr_o, 32'h0000_0200);
      chk_val({tag, "_we"}, 32'(data_we_o), 32'd1);
      chk_val({tag, "_be"}, 32'(data_be_o), 32'h3);
      chk_val({tag, "_wdata"}, data_wdata_o, 32'h2222_2222);
    end
    chk_val({tag, "_gnt0"}, 32'(m0_gnt_o), 32'(sel == 0 && g));
    chk_val({tag, "_gnt1"}, 32'(m1_gnt_o), 32'(sel == 1 && g));
    chk_val({tag, "_rv0"}, 32'(m0_rvalid_o), 32'(e_rv0));
    chk_val({tag, "_rv1"}, 32'(m1_rvalid_o), 32'(e_rv1));
    if (rv) begin
      chk_val({tag, "_rd0"}, m0_rdata_o, rd);
      chk_val({tag, "_rd1"}, m1_rdata_o, rd);
    end
    if (sel >= 0 && g) sb_q.push_back(sel);
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles with live inputs to prove outputs are gated; drops all expectations.
  task automatic do_reset();
    rst = 1'b1;
    m0_req_i = 1'b1; m1_req_i = 1'b1; data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_val("rst_req", 32'(data_req_o), 32'd0);
      chk_val("rst_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'd0);
      chk_val("rst_rv", 32'({m1_rvalid_o, m0_rvalid_o}), 32'd0);
      chk_val("rst_addr", data_addr_o, 32'h0000_0100);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    m0_req_i = 1'b0; m1_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    m0_addr_i = 32'h0000_0100; m0_we_i = 1'b0; m0_be_i = 4'hF; m0_wdata_i = 32'h1111_1111;
    m1_addr_i = 32'h0000_0200; m1_we_i = 1'b1; m1_be_i = 4'h3; m1_wdata_i = 32'h2222_2222;
    data_rdata_i = '0;
    @(posedge clk);
    #1;

    // Reset and idle
    do_reset();
    chk_val("idle_cnt", 32'(dut.cnt_q), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, -1, "idle");

    // Single master read, response two cycles after the grant
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0, "rd_req");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, -1, "rd_gap");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, -1, "rd_rsp");

    // Contention: alternating grants starting from master 0 after reset
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 0, "rr0");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'hA000_0001, 1, "rr1");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'hA000_0002, 0, "rr2");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'hA000_0003, 1, "rr3");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0004, -1, "rr_drain");

    // Lock: m1 keeps the port through three stalled cycles despite m0 having priority
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1, "lk0");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1, "lk1");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1, "lk2");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1, "lk3");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0, "lk4");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hB000_0001, -1, "lk_d0");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hB000_0002, -1, "lk_d1");

    // Outstanding limit, then grant alongside a pop while full
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0, "ol0");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0, "ol1");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, -1, "ol_full");
    chk_val("ol_cnt_full", 32'(dut.cnt_q), 32'd2);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'hC000_0001, 0, "ol_pop");
    chk_val("ol_cnt_same", 32'(dut.cnt_q), 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hC000_0002, -1, "ol_d0");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hC000_0003, -1, "ol_d1");
    chk_val("ol_cnt_empty", 32'(dut.cnt_q), 32'd0);

    // Response routing m1, m0, m1, then a spurious rvalid
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1, "rt_g0");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0, "rt_g1");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hD000_0001, 1, "rt_g2");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hD000_0002, -1, "rt_r1");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hD000_0003, -1, "rt_r2");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hD000_0004, -1, "rt_spur");
    chk_val("rt_cnt", 32'(dut.cnt_q), 32'd0);

    // Reset mid-transaction: the later response is spurious
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0, "mid_g");
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hE000_0001, -1, "mid_rsp");
    chk_val("mid_cnt", 32'(dut.cnt_q), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_port_arbiter.md
# data_port_arbiter

Two-master arbiter that shares the core's single data-memory port (data_req/gnt/rvalid handshake) between the load/store unit (master 0) and a debug/DMA master (master 1). It picks one requester, forwards its request fields to memory, and locks that choice until the grant. It records the owner of every outstanding transaction in an in-order ID FIFO so that each data_rvalid_i/data_rdata_i response is routed back to the correct master. The block sits between the LSU/debug masters and the data memory interface.

## Interface
- MAX_OUT, default 2: maximum outstanding (granted, not yet responded) transactions; allowed range 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- mN_req_i  in  1  request from master N (N = 0, 1).
- mN_addr_i  in  32  address from master N.
- mN_we_i  in  1  write enable from master N (1 = write, 0 = read).
- mN_be_i  in  4  byte enables from master N.
- mN_wdata_i  in  32  write data from master N.
- mN_gnt_o  out  1  grant to master N.
- mN_rvalid_o  out  1  response valid to master N.
- mN_rdata_o  out  32  read data to master N; equals data_rdata_i.
- data_req_o, data_addr_o[31:0], data_we_o, data_be_o[3:0], data_wdata_o[31:0]  out  memory request fields.
- data_gnt_i  in  1  memory grant.
- data_rvalid_i  in  1  memory response valid.
- data_rdata_i  in  32  memory read data.

## Operation
- State: owner lock (IDLE, LOCK0, LOCK1), round-robin pointer rr (1 bit, the preferred master), ID FIFO of MAX_OUT 1-bit entries, and an occupancy count cnt (0..MAX_OUT).
- Selection in IDLE:
  - Only one mN_req_i high: that master is selected.
  - Both high: master rr is selected.
  - If cnt == MAX_OUT and no pop occurs this cycle, no master is selected and data_req_o = 0.
- Forwarding: the selected master's addr/we/be/wdata drive data_*_o. data_req_o = 1. mN_gnt_o = data_gnt_i for the selected master and 0 for the other. Outputs are combinational from the selection.
- IDLE to LOCKN: master N is selected and data_gnt_i = 0. In LOCKN, master N stays selected regardless of the other master's request or rr, so the address stays stable until the grant.
- LOCKN to IDLE: on data_gnt_i = 1.
- If mN_req_i drops while in LOCKN (protocol violation), go to IDLE with no FIFO push.
- On each grant:
  - Push the owner ID into the FIFO.
  - rr <= the ID of the other master.
- On each data_rvalid_i:
  - Pop the FIFO head.
  - Assert m{head}_rvalid_o for that cycle only.
- Simultaneous push and pop: cnt is unchanged, and both operations take effect.
- A pop with an empty FIFO (spurious rvalid) is ignored: no mN_rvalid_o is asserted and cnt stays 0.
- Full-plus-pop: a grant is allowed in the same cycle as a pop even when cnt == MAX_OUT.
- mN_rdata_o = data_rdata_i unconditionally. Masters qualify the data with mN_rvalid_o.

## Timing
- Request path: combinational. A master request that is granted in the same cycle it is raised has 0 cycles of arbiter latency.
- Response path: combinational from data_rvalid_i to mN_rvalid_o, with no added latency.
- Reset effect: lock = IDLE, rr = 0, FIFO empty, cnt = 0.
- Output values while rst is high: data_req_o = 0, all mN_gnt_o = 0, all mN_rvalid_o = 0. The remaining data_*_o outputs follow master 0's inputs (don't-care, but deterministic).
- Reset mid-transaction: outstanding responses are discarded. Any rvalid arriving after reset is treated as spurious.
- The FIFO read and write pointers wrap modulo MAX_OUT.

## Test plan
- Reset and idle: hold rst = 1 for 2 cycles, then release with no requests. Expect data_req_o = 0, gnt and rvalid both 0, cnt = 0.
- Single master read: m0 requests addr 0x100 with be = 4'hF, we = 0, data_gnt_i = 1 in the same cycle, then data_rvalid_i two cycles later with rdata 0xDEADBEEF. Expect m0_gnt_o for 1 cycle, and m0_rvalid_o with m0_rdata_o = 0xDEADBEEF; m1_rvalid_o stays 0.
- Contention and fairness: both masters request continuously with data_gnt_i = 1 every cycle. Expect grants in the order m0, m1, m0, m1.
- Lock: m1 requests, data_gnt_i is held low for 3 cycles, and m0 raises its request in cycle 1. Expect data_addr_o = m1_addr_i for all 4 cycles and m1 granted first.
- Outstanding limit (MAX_OUT = 2): two grants with no rvalid. Expect data_req_o = 0 with a third request pending. Then, in one cycle, assert rvalid together with the pending request. Expect a grant in that same cycle and cnt to remain 2.
- Response routing: issue grants in the order m1, m0, m1, then three rvalids. Expect mN_rvalid_o to fire for m1, m0, m1 in that order. A fourth, spurious rvalid produces no mN_rvalid_o.
